// File: rtl/yolo_conv_top_mul_arbiter.sv
// Round-robin arbiter that shares one unsigned x signed multiplier among NUM_REQ
// requesters through a two-stage pipeline, returning the requester tag with each product.
`timescale 1ns/1ps
module yolo_conv_top_mul_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2,
    parameter int A_WIDTH  = 6,
    parameter int B_WIDTH  = 16,
    parameter int P_WIDTH  = 22
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [P_WIDTH-1:0]           res_p,
    output logic [ID_WIDTH-1:0]          res_id,
    output logic                         busy
);

    logic                s1_valid_q, s1_valid_d;
    logic [A_WIDTH-1:0]  s1_a_q, s1_a_d;
    logic [B_WIDTH-1:0]  s1_b_q, s1_b_d;
    logic [ID_WIDTH-1:0] s1_id_q, s1_id_d;
    logic                s2_valid_q, s2_valid_d;
    logic [P_WIDTH-1:0]  s2_p_q, s2_p_d;
    logic [ID_WIDTH-1:0] s2_id_q, s2_id_d;
    logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

    logic                s2_load, s1_adv, s1_free;
    logic                grant_found;
    logic [ID_WIDTH-1:0] grant_id;
    logic [NUM_REQ-1:0]  grant_vec;
    logic                transfer;

    logic signed [P_WIDTH-1:0] op_a_ext, op_b_ext, prod;

    always_comb begin
        s2_load = !s2_valid_q || res_ready;
        s1_adv  = s1_valid_q && s2_load;
        s1_free = !s1_valid_q || s1_adv;
    end

    // Scan from rr_ptr upward with wrap-around; first valid requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = ID_WIDTH'(idx);
            end
        end
    end

    // Reset gates the grant so nothing is accepted while ap_rst is high.
    always_comb begin
        transfer  = s1_free && grant_found && !ap_rst;
        grant_vec = '0;
        if (transfer) begin
            grant_vec[grant_id] = 1'b1;
        end
    end

    assign req_ready = grant_vec;

    always_comb begin
        op_a_ext = signed'(P_WIDTH'(s1_a_q));
        op_b_ext = {{(P_WIDTH-B_WIDTH){s1_b_q[B_WIDTH-1]}}, s1_b_q};
        prod     = op_a_ext * op_b_ext;
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_id_d    = s1_id_q;
        rr_ptr_d   = rr_ptr_q;
        if (transfer) begin
            s1_valid_d = 1'b1;
            s1_a_d     = req_a[int'(grant_id)*A_WIDTH +: A_WIDTH];
            s1_b_d     = req_b[int'(grant_id)*B_WIDTH +: B_WIDTH];
            s1_id_d    = grant_id;
            rr_ptr_d   = (grant_id == ID_WIDTH'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    // s2 only changes when it may load; otherwise the presented result holds.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_p_d     = s2_p_q;
        s2_id_d    = s2_id_q;
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_p_d  = prod;
                s2_id_d = s1_id_q;
            end
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_p_q     <= '0;
            s2_id_q    <= '0;
            rr_ptr_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_id_q    <= s1_id_d;
            s2_valid_q <= s2_valid_d;
            s2_p_q     <= s2_p_d;
            s2_id_q    <= s2_id_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign res_valid = s2_valid_q;
    assign res_p     = s2_p_q;
    assign res_id    = s2_id_q;
    assign busy      = s1_valid_q || s2_valid_q;

endmodule

// File: tb/tb_yolo_conv_top_mul_arbiter.sv
// Self-checking bench for the shared-multiplier arbiter: product vectors, directed
// multi-cycle sequences, and a randomized run against a queue-based reference model.
`timescale 1ns/1ps
module tb_yolo_conv_top_mul_arbiter;

    localparam int NR = 4;

    logic          ap_clk = 1'b0;
    logic          ap_rst;
    logic [NR-1:0] req_valid;
    logic [NR-1:0] req_ready;
    logic [NR*6-1:0]  req_a;
    logic [NR*16-1:0] req_b;
    logic          res_valid;
    logic          res_ready;
    logic [21:0]   res_p;
    logic [1:0]    res_id;
    logic          busy;

    int checks = 0;
    int errors = 0;

    yolo_conv_top_mul_arbiter dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_p(res_p), .res_id(res_id), .busy(busy)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        int id;
        int a;
        int b;
        int p;
    } vec_t;

    typedef struct {
        int p;
        int id;
        int acc;
    } exp_t;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic set_req(input int i, input int a, input int b);
        logic [5:0]  av;
        logic [15:0] bv;
        av = a[5:0];
        bv = b[15:0];
        req_a[i*6 +: 6]   = av;
        req_b[i*16 +: 16] = bv;
    endtask

    function automatic int pv();
        return int'($signed(res_p));
    endfunction

    // Leaves the bench in cycle 0 after reset release, 1ns past the edge.
    task automatic do_reset(input logic [NR-1:0] v);
        ap_rst    = 1'b1;
        req_valid = v;
        tick();
        #1;
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_res_p", pv(), 0);
        chk("rst_res_id", int'(res_id), 0);
        chk("rst_busy", int'(busy), 0);
        tick();
        ap_rst = 1'b0;
    endtask

    vec_t vecs[8];
    exp_t q[$];

    initial begin
        int   xfers;
        int   rr_m;
        int   pa[NR];
        int   pb[NR];
        bit   pend[NR];

        ap_rst    = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;

        vecs[0] = '{1,  5,     -7,      -35};
        vecs[1] = '{0, 63, -32768, -2064384};
        vecs[2] = '{2, 63,  32767,  2064321};
        vecs[3] = '{3,  0,     -1,        0};
        vecs[4] = '{1,  1,      1,        1};
        vecs[5] = '{2, 10,   -100,    -1000};
        vecs[6] = '{3, 63,     -1,      -63};
        vecs[7] = '{0, 33,   1000,    33000};

        // Single-request product vectors
        do_reset('0);
        for (int v = 0; v < 8; v++) begin
            set_req(vecs[v].id, vecs[v].a, vecs[v].b);
            req_valid = NR'(1) << vecs[v].id;
            #1;
            chk("vec_ready", int'(req_ready), 1 << vecs[v].id);
            tick();
            req_valid = '0;
            #1;
            chk("vec_ready_once", int'(req_ready), 0);
            chk("vec_early_valid", int'(res_valid), 0);
            chk("vec_busy", int'(busy), 1);
            tick();
            chk("vec_valid", int'(res_valid), 1);
            chk("vec_p", pv(), vecs[v].p);
            chk("vec_id", int'(res_id), vecs[v].id);
            tick();
            chk("vec_drained", int'(res_valid), 0);
        end

        // All four held from reset
        for (int i = 0; i < NR; i++) set_req(i, i + 1, 100);
        res_ready = 1'b1;
        do_reset(4'b1111);
        for (int c = 0; c < 6; c++) begin
            if (c >= 1 && c <= 4) req_valid[c-1] = 1'b0;
            if (c >= 2) begin
                chk("all4_valid", int'(res_valid), 1);
                chk("all4_p", pv(), (c - 1) * 100);
                chk("all4_id", int'(res_id), c - 2);
            end else begin
                chk("all4_valid_early", int'(res_valid), 0);
            end
            #1;
            if (c < 4) chk("all4_grant", int'(req_ready), 1 << c);
            tick();
        end
        req_valid = '0;

        // Fairness between req0 and req2
        set_req(0, 1, 1);
        set_req(2, 2, 2);
        do_reset(4'b0101);
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("fair_grant", int'(req_ready), (c % 2 == 0) ? 1 : 4);
            tick();
        end
        req_valid = '0;

        // Back-pressure: two transfers then stall, then drain in order
        res_ready = 1'b0;
        set_req(0, 3, 7);
        do_reset(4'b0001);
        xfers = 0;
        for (int c = 0; c < 6; c++) begin
            if (c == 1) set_req(0, 4, 7);
            if (c >= 2) begin
                chk("bp_valid", int'(res_valid), 1);
                chk("bp_p_hold", pv(), 21);
                chk("bp_id_hold", int'(res_id), 0);
            end
            #1;
            if (|(req_valid & req_ready)) xfers++;
            if (c >= 2) chk("bp_ready_low", int'(req_ready), 0);
            tick();
        end
        chk("bp_xfers", xfers, 2);
        req_valid = '0;
        res_ready = 1'b1;
        chk("bp_drain0_valid", int'(res_valid), 1);
        chk("bp_drain0_p", pv(), 21);
        tick();
        chk("bp_drain1_valid", int'(res_valid), 1);
        chk("bp_drain1_p", pv(), 28);
        tick();
        chk("bp_drain_done", int'(res_valid), 0);

        // Async reset with both stages full; rr_ptr would otherwise point at 3
        res_ready = 1'b0;
        set_req(2, 9, 9);
        do_reset(4'b0100);
        tick();
        tick();
        chk("ar_full_valid", int'(res_valid), 1);
        chk("ar_full_busy", int'(busy), 1);
        #3;
        ap_rst = 1'b1;
        #1;
        chk("ar_valid_drop", int'(res_valid), 0);
        chk("ar_busy_drop", int'(busy), 0);
        chk("ar_ready_low", int'(req_ready), 0);
        req_valid = '0;
        tick();
        tick();
        ap_rst    = 1'b0;
        res_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("ar_no_stale", int'(res_valid), 0);
            chk("ar_idle", int'(busy), 0);
        end
        set_req(1, 2, -3);
        set_req(3, 5, 5);
        req_valid = 4'b1010;
        #1;
        chk("ar_rr_grant", int'(req_ready), 2);
        tick();
        req_valid = '0;
        tick();
        chk("ar_res_valid", int'(res_valid), 1);
        chk("ar_res_p", pv(), -6);
        chk("ar_res_id", int'(res_id), 1);
        tick();

        // Randomized run against an in-order queue model
        res_ready = 1'b1;
        do_reset('0);
        rr_m = 0;
        q.delete();
        for (int i = 0; i < NR; i++) pend[i] = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            bit                exp_rv;
            bit                free;
            int                pick;
            logic [NR-1:0]     exp_rdy;
            exp_rv = (q.size() > 0) && (q[0].acc <= n - 2);
            chk("rnd_busy", int'(busy), int'(q.size() > 0));
            chk("rnd_valid", int'(res_valid), int'(exp_rv));
            if (exp_rv) begin
                chk("rnd_p", pv(), q[0].p);
                chk("rnd_id", int'(res_id), q[0].id);
            end
            for (int i = 0; i < NR; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        pend[i] = 1'b1;
                        pa[i] = ($urandom_range(0, 7) == 0) ? 63 : int'($urandom_range(0, 63));
                        pb[i] = ($urandom_range(0, 7) == 0) ? -32768 : int'($urandom_range(0, 65535)) - 32768;
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    pend[i] = 1'b0;
                end
                req_valid[i] = pend[i];
                set_req(i, pa[i], pb[i]);
            end
            res_ready = ($urandom_range(0, 3) != 0);
            #1;
            free = (q.size() < 2) || res_ready;
            pick = -1;
            for (int k = 0; k < NR; k++) begin
                int idx;
                idx = (rr_m + k) % NR;
                if (pick < 0 && pend[idx]) pick = idx;
            end
            exp_rdy = (free && pick >= 0) ? (NR'(1) << pick) : '0;
            chk("rnd_ready", int'(req_ready), int'(exp_rdy));
            if (exp_rv && res_ready) void'(q.pop_front());
            if (exp_rdy != '0) begin
                q.push_back('{pa[pick] * pb[pick], pick, n});
                pend[pick] = 1'b0;
                rr_m = (pick + 1) % NR;
            end
            tick();
        end
        req_valid = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/yolo_conv_top_mul_arbiter.md
Name: yolo_conv_top_mul_arbiter

Overview:
- Shares one 6-bit-unsigned × 16-bit-signed → 22-bit multiplier among NUM_REQ requesters inside yolo_conv_top.
- Requesters are, for example, kernel-index × weight address/scale computations in the conv loop nest.
- Round-robin arbitration, valid/ready handshakes on both sides, a two-stage registered pipeline, and a requester tag returned with each product.
- Sits between the conv loop controllers and the shared multiplier, so the design needs one multiplier instance instead of one per loop.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_WIDTH, 2, tag width; must equal clog2(NUM_REQ).
- A_WIDTH, 6, unsigned operand width.
- B_WIDTH, 16, signed operand width.
- P_WIDTH, 22, product width; must equal A_WIDTH+B_WIDTH.

Ports:
- ap_clk  in  1  clock; all state changes on its rising edge.
- ap_rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  bit i: requester i presents operands.
- req_ready  out  NUM_REQ  bit i: requester i's operands are accepted this cycle.
- req_a  in  NUM_REQ*A_WIDTH  requester i operand a at [i*A_WIDTH +: A_WIDTH], unsigned.
- req_b  in  NUM_REQ*B_WIDTH  requester i operand b at [i*B_WIDTH +: B_WIDTH], signed.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_p  out  P_WIDTH  signed product.
- res_id  out  ID_WIDTH  index of the requester that produced res_p.
- busy  out  1  at least one operation in flight.

Behaviour:
- Reset state, asynchronous, effective immediately:
  - s1_valid=0, s2_valid=0, rr_ptr=0.
  - res_valid=0, res_p=0, res_id=0, busy=0.
  - req_ready=0 while ap_rst is high.
- Reset mid-operation: in-flight operations are discarded. No res_valid is produced for them after reset deasserts.
- Arithmetic: p = $signed({1'b0,a}) * $signed(b), exact 22-bit signed result; no truncation or overflow is possible.
  - Range is -2064384..2064321.
- Pipeline:
  - Stage 1 (s1) registers a, b and id.
  - Stage 2 (s2) registers p and id and drives res_p, res_id and res_valid=s2_valid.
- Advance conditions:
  - s2_load = !s2_valid | res_ready.
  - s1_adv = s1_valid & s2_load.
  - s1_free = !s1_valid | s1_adv.
- Grant:
  - When s1_free, grant the first i with req_valid[i]=1, scanning from rr_ptr upward with wrap-around modulo NUM_REQ.
  - req_ready is one-hot (grant) or all-zero; it is combinational from req_valid and pipeline state.
  - Transfer occurs on req_valid[i] & req_ready[i].
- Pointer update: on a transfer from i, rr_ptr <= (i+1) mod NUM_REQ. With no transfer, rr_ptr holds.
- Requester rules:
  - A requester must hold req_valid and its operands stable until accepted.
  - Dropping req_valid before acceptance is legal; that request is simply not served.
- Latency:
  - A transfer in cycle t gives res_valid=1 in cycle t+2 when no back-pressure is present.
  - Throughput is one result per cycle while res_ready=1.
- Back-pressure:
  - While res_valid=1 and res_ready=0, res_p and res_id hold stable and s2 does not load.
  - s1 may still fill if empty, so at most 2 operations are buffered.
  - req_ready is 0 once both stages are full.
- Simultaneous events:
  - Results dequeue and a new result loads into s2 in the same cycle, with no bubble.
  - s1 accepts a new request in the same cycle it advances.
- busy = s1_valid | s2_valid.
- Ordering: results leave in acceptance order.
- No starvation: a held request is granted within NUM_REQ transfers.

Test Plan:
- Single request: req_valid=4'b0010, a=5, b=-7, res_ready=1.
  - req_ready=4'b0010 for exactly one cycle.
  - Two cycles later: res_valid=1, res_p=-35, res_id=1.
- All four requests held from reset, with a=i+1, b=100, res_ready=1.
  - Grants in order 0,1,2,3, one per cycle.
  - Results 100,200,300,400 with ids 0..3 on consecutive cycles.
- Fairness: req0 and req2 held continuously.
  - Grant sequence is 0,2,0,2,…
  - rr_ptr after each grant is 1,3,1,3.
- Back-pressure: res_ready=0 for 6 cycles while req0 is held.
  - Exactly 2 transfers occur, then req_ready=0.
  - res_p/res_id remain stable.
  - When res_ready is released, results drain on consecutive cycles in order.
- Boundaries:
  - a=63, b=-32768 gives res_p=-2064384 (22'h208000).
  - a=63, b=32767 gives 2064321.
  - a=0, b=-1 gives 0.
- Async reset mid-flight: assert ap_rst between clock edges with both stages full.
  - res_valid and busy drop immediately.
  - After release, no stale result appears.
  - The next request is served with rr_ptr=0 priority.
